// File: rtl/plic_irq_gateway.sv
// Purpose: conditions raw peripheral interrupt lines for the PLIC `sources` input.
//   Each line is synchronised, then passed through in level mode. In edge mode it is
//   held as a request until completion, with a saturating backlog count of extra edges.
// Ports: clk/reset (async active-high); irq_in raw lines; edge_mode per-source mode;
//   complete_valid/complete_id completion strobe (id k -> bit k-1); ovf_clear W1C;
//   sources conditioned requests; ovf sticky backlog-overflow flags.
// Latency: irq_in to sources is SYNC_STAGES+1 cycles. No combinational input-to-output path.
module plic_irq_gateway #(
  parameter int N_SRC       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] edge_mode,
  input  logic             complete_valid,
  input  logic [5:0]       complete_id,
  input  logic [N_SRC-1:0] ovf_clear,
  output logic [N_SRC-1:0] sources,
  output logic [N_SRC-1:0] ovf
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] hist_q;
  logic [N_SRC-1:0] mode_q;

  state_t           state_q   [N_SRC];
  state_t           state_nxt [N_SRC];
  logic [CNT_W-1:0] cnt_q     [N_SRC];
  logic [CNT_W-1:0] cnt_nxt   [N_SRC];

  logic [N_SRC-1:0] lvl;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mode_chg;
  logic [N_SRC-1:0] comp_hit;
  logic [N_SRC-1:0] ovf_set;
  logic [N_SRC-1:0] src_nxt;

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign rise     = lvl & ~hist_q;
  assign mode_chg = edge_mode ^ mode_q;

  // Id k targets bit k-1; id 0 and ids beyond N_SRC match nothing.
  always_comb begin
    comp_hit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      comp_hit[i] = complete_valid && (complete_id == 6'(i + 1));
    end
  end

  // Synchroniser chain and edge-history flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      hist_q <= '0;
      mode_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      hist_q <= lvl;
      mode_q <= edge_mode;
    end
  end

  // Per-source FSM/counter next-state logic.
  always_comb begin
    ovf_set = '0;
    src_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      state_nxt[i] = state_q[i];
      cnt_nxt[i]   = cnt_q[i];
      if (mode_chg[i] || !edge_mode[i]) begin
        // A mode switch discards any in-flight request; level mode keeps the FSM parked.
        state_nxt[i] = IDLE;
        cnt_nxt[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) state_nxt[i] = ACTIVE;
          end
          ACTIVE: begin
            if (rise[i] && comp_hit[i]) begin
              // The new edge replaces the completed one: backlog unchanged, nothing dropped.
              state_nxt[i] = ACTIVE;
            end else if (rise[i]) begin
              if (cnt_q[i] != CNT_MAX) cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
              else                     ovf_set[i] = 1'b1;
            end else if (comp_hit[i]) begin
              // Staying ACTIVE with backlog keeps sources high so the PLIC re-pends.
              if (cnt_q[i] != '0) cnt_nxt[i]   = cnt_q[i] - CNT_W'(1);
              else                state_nxt[i] = IDLE;
            end
          end
          default: state_nxt[i] = IDLE;
        endcase
      end
      src_nxt[i] = edge_mode[i] ? (state_nxt[i] == ACTIVE) : lvl[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      sources <= '0;
      ovf     <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        state_q[i] <= state_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
      end
      sources <= src_nxt;
      // A same-cycle overflow wins over the software clear.
      ovf     <= ovf_set | (ovf & ~ovf_clear);
    end
  end

endmodule

// File: tb/tb_plic_irq_gateway.sv
module tb_plic_irq_gateway;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] irq_in;
  logic [31:0] edge_mode;
  logic        complete_valid;
  logic [5:0]  complete_id;
  logic [31:0] ovf_clear;
  logic [31:0] sources;
  logic [31:0] ovf;

  int checks = 0;
  int errors = 0;

  plic_irq_gateway #(.N_SRC(32), .SYNC_STAGES(2), .CNT_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .edge_mode      (edge_mode),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .ovf_clear      (ovf_clear),
    .sources        (sources),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse followed by two low cycles; the rise is taken on the third edge.
  task automatic pulse(input int idx);
    irq_in[idx] = 1'b1;
    tick();
    irq_in[idx] = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_complete(input int id);
    complete_valid = 1'b1;
    complete_id    = 6'(id);
    tick();
    complete_valid = 1'b0;
    complete_id    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    irq_in = '1;
    edge_mode = '0;
    complete_valid = 1'b0;
    complete_id = '0;
    ovf_clear = '0;
    repeat (3) tick();
    checks++;
    if (sources !== 32'h0 || ovf !== 32'h0) begin
      $display("FAIL reset_hold: sources=%h ovf=%h expected 0/0", sources, ovf);
      errors++;
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (sources !== 32'h0) begin
      $display("FAIL reset_lat2: sources=%h expected 00000000", sources);
      errors++;
    end
    tick();
    checks++;
    if (sources !== 32'hFFFF_FFFF) begin
      $display("FAIL reset_lat3: sources=%h expected ffffffff", sources);
      errors++;
    end
    irq_in = '0;
    repeat (4) tick();
    checks++;
    if (sources !== 32'h0) begin
      $display("FAIL level_low: sources=%h expected 00000000", sources);
      errors++;
    end
    edge_mode = 32'h0000_009D;
    repeat (2) tick();
  endtask

  task automatic test_edge_single();
    irq_in[4] = 1'b1;
    tick();
    irq_in[4] = 1'b0;
    tick();
    checks++;
    if (sources[4] !== 1'b0) begin
      $display("FAIL single_early: sources[4]=%b expected 0", sources[4]);
      errors++;
    end
    tick();
    checks++;
    if (sources[4] !== 1'b1) begin
      $display("FAIL single_rise: sources[4]=%b expected 1", sources[4]);
      errors++;
    end
    repeat (4) tick();
    checks++;
    if (sources[4] !== 1'b1) begin
      $display("FAIL single_hold: sources[4]=%b expected 1", sources[4]);
      errors++;
    end
    do_complete(5);
    checks++;
    if (sources[4] !== 1'b0) begin
      $display("FAIL single_done: sources[4]=%b expected 0", sources[4]);
      errors++;
    end
  endtask

  task automatic test_backlog();
    pulse(0);
    repeat (3) pulse(0);
    for (int k = 0; k < 3; k++) begin
      do_complete(1);
      checks++;
      if (sources[0] !== 1'b1) begin
        $display("FAIL backlog_hold%0d: sources[0]=%b expected 1", k, sources[0]);
        errors++;
      end
    end
    do_complete(1);
    checks++;
    if (sources[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      $display("FAIL backlog_drop: sources[0]=%b ovf[0]=%b expected 0/0", sources[0], ovf[0]);
      errors++;
    end
  endtask

  task automatic test_saturation();
    pulse(2);
    repeat (7) pulse(2);
    checks++;
    if (ovf[2] !== 1'b0) begin
      $display("FAIL sat_at_max: ovf[2]=%b expected 0", ovf[2]);
      errors++;
    end
    repeat (2) pulse(2);
    checks++;
    if (ovf[2] !== 1'b1) begin
      $display("FAIL sat_ovf: ovf[2]=%b expected 1", ovf[2]);
      errors++;
    end
    ovf_clear[2] = 1'b1;
    tick();
    ovf_clear[2] = 1'b0;
    checks++;
    if (ovf[2] !== 1'b0) begin
      $display("FAIL sat_clear: ovf[2]=%b expected 0", ovf[2]);
      errors++;
    end
    // Rise lands in the cycle after the second edge; clear coincides with it.
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    tick();
    ovf_clear[2] = 1'b1;
    tick();
    ovf_clear[2] = 1'b0;
    checks++;
    if (ovf[2] !== 1'b1) begin
      $display("FAIL sat_set_wins: ovf[2]=%b expected 1", ovf[2]);
      errors++;
    end
    // Backlog is 7: seven completes keep the request, the eighth retires it.
    repeat (7) do_complete(3);
    checks++;
    if (sources[2] !== 1'b1) begin
      $display("FAIL sat_drain7: sources[2]=%b expected 1", sources[2]);
      errors++;
    end
    do_complete(3);
    checks++;
    if (sources[2] !== 1'b0) begin
      $display("FAIL sat_drain8: sources[2]=%b expected 0", sources[2]);
      errors++;
    end
  endtask

  task automatic test_simultaneous();
    pulse(7);
    irq_in[7] = 1'b1;
    tick();
    irq_in[7] = 1'b0;
    tick();
    do_complete(8);
    checks++;
    if (sources[7] !== 1'b1) begin
      $display("FAIL simul_hold: sources[7]=%b expected 1", sources[7]);
      errors++;
    end
    do_complete(8);
    checks++;
    if (sources[7] !== 1'b0) begin
      $display("FAIL simul_drop: sources[7]=%b expected 0", sources[7]);
      errors++;
    end
  endtask

  task automatic test_ignored_ids();
    irq_in[1] = 1'b1;
    pulse(4);
    repeat (2) tick();
    checks++;
    if (sources !== 32'h0000_0012) begin
      $display("FAIL ign_setup: sources=%h expected 00000012", sources);
      errors++;
    end
    do_complete(0);
    do_complete(40);
    do_complete(33);
    do_complete(2);
    checks++;
    if (sources !== 32'h0000_0012 || ovf !== 32'h0000_0004) begin
      $display("FAIL ign_ids: sources=%h ovf=%h expected 00000012/00000004", sources, ovf);
      errors++;
    end
    do_complete(5);
    checks++;
    if (sources !== 32'h0000_0002) begin
      $display("FAIL ign_real: sources=%h expected 00000002", sources);
      errors++;
    end
    irq_in[1] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_mode_change();
    pulse(3);
    repeat (2) pulse(3);
    edge_mode[3] = 1'b0;
    tick();
    checks++;
    if (sources[3] !== 1'b0) begin
      $display("FAIL mode_to_level: sources[3]=%b expected 0", sources[3]);
      errors++;
    end
    edge_mode[3] = 1'b1;
    tick();
    tick();
    checks++;
    if (sources[3] !== 1'b0) begin
      $display("FAIL mode_to_edge: sources[3]=%b expected 0", sources[3]);
      errors++;
    end
    pulse(3);
    checks++;
    if (sources[3] !== 1'b1) begin
      $display("FAIL mode_rearm: sources[3]=%b expected 1", sources[3]);
      errors++;
    end
    // Backlog was discarded, so one complete retires the request.
    do_complete(4);
    checks++;
    if (sources[3] !== 1'b0) begin
      $display("FAIL mode_cnt0: sources[3]=%b expected 0", sources[3]);
      errors++;
    end
  endtask

  task automatic test_reset_mid_service();
    pulse(0);
    pulse(0);
    checks++;
    if (sources[0] !== 1'b1 || ovf !== 32'h0000_0004) begin
      $display("FAIL mid_setup: sources[0]=%b ovf=%h expected 1/00000004", sources[0], ovf);
      errors++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (sources !== 32'h0 || ovf !== 32'h0) begin
      $display("FAIL mid_async: sources=%h ovf=%h expected 0/0", sources, ovf);
      errors++;
    end
    tick();
    reset = 1'b0;
    repeat (4) tick();
    checks++;
    if (sources !== 32'h0 || ovf !== 32'h0) begin
      $display("FAIL mid_after: sources=%h ovf=%h expected 0/0", sources, ovf);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_backlog();
    test_saturation();
    test_simultaneous();
    test_ignored_ids();
    test_mode_change();
    test_reset_mid_service();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_irq_gateway.md
Name: plic_irq_gateway

Overview:
- Sits between raw peripheral interrupt lines and the `sources` input of the plic wrapper.
- Per source, it:
  - synchronises the line;
  - applies level or edge mode;
  - holds edge requests high until the hart signals completion;
  - counts edges that arrive while a request is in service, so the PLIC's level gateways never lose an interrupt.
- Completion is a strobe from the bus snooper that decodes writes to the PLIC claim/complete register.

Parameters:
- N_SRC, 32, number of interrupt sources; must equal the plic `sources` width.
- SYNC_STAGES, 2, flip-flop synchroniser depth, minimum 2.
- CNT_W, 3, width of the per-source edge backlog counter; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- irq_in  in  N_SRC  raw asynchronous interrupt lines, active-high.
- edge_mode  in  N_SRC  per-source mode: 1 = rising-edge, 0 = level; quasi-static.
- complete_valid  in  1  one-cycle strobe: hart wrote complete for complete_id.
- complete_id  in  6  completed PLIC id; id k maps to bit k-1; id 0 and ids > N_SRC are ignored.
- ovf_clear  in  N_SRC  per-source write-1-to-clear for ovf.
- sources  out  N_SRC  conditioned requests to the plic `sources` input.
- ovf  out  N_SRC  sticky flag: an edge was dropped because the backlog counter was saturated.

Behaviour:
- Reset (async assert, sync release):
  - all synchroniser flops and edge-history flops = 0;
  - all sources = 0, all ovf = 0, all counters = 0, all FSMs = IDLE.
- Synchroniser: SYNC_STAGES flops per bit, then one history flop.
  - s = synchronised level; rise = s & ~history.
- Level mode (edge_mode[i]=0):
  - sources[i] is registered s;
  - latency irq_in to sources = SYNC_STAGES+1 cycles;
  - FSM and counter held at IDLE/0; complete ignored.
- Edge mode, per-source FSM (IDLE, ACTIVE); sources[i] = (state==ACTIVE), registered.
  - IDLE: rise -> ACTIVE; sources high SYNC_STAGES+1 cycles after the irq_in edge.
  - ACTIVE, rise without matching complete: cnt += 1 if cnt < max; else set ovf[i].
  - ACTIVE, matching complete, cnt > 0: stay ACTIVE, cnt -= 1; sources stays high, so the PLIC re-pends the source.
  - ACTIVE, matching complete, cnt == 0: go to IDLE; sources low next cycle.
  - ACTIVE, matching complete and rise in the same cycle: net cnt unchanged, stay ACTIVE. The edge is never dropped, even if cnt == 0 or saturated.
  - IDLE, matching complete: ignored (spurious).
- Mode change:
  - any change of edge_mode[i] (detected by a registered copy) forces state IDLE and cnt 0 next cycle;
  - sources[i] follows the new mode from the cycle after;
  - ovf untouched.
- ovf[i]:
  - set has priority over ovf_clear[i] in the same cycle;
  - otherwise ovf_clear[i] clears it.
- complete_id decode:
  - exactly one bit at most is affected per strobe;
  - complete_valid with an out-of-range id has no effect.
- Reset mid-service: everything returns to reset values; outstanding backlog is lost by design.
- No combinational path from any input to any output.

Test Plan:
- Reset (SYNC_STAGES=2, CNT_W=3): assert reset with irq_in=all 1s, level mode -> sources=0 during reset; release -> sources=all 1s exactly 3 cycles later.
- Edge single request: edge_mode[4]=1, pulse irq_in[4] for 1 cycle -> sources[4]=1 on cycle 3 and held; complete_id=5 -> sources[4]=0 next cycle.
- Edge backlog: source 0 ACTIVE, three further pulses -> cnt=3. Then:
  - three completes with id 1 -> sources[0] stays 1;
  - fourth complete -> sources[0] drops;
  - ovf[0]=0 throughout.
- Saturation: source 2 ACTIVE, 9 further pulses -> cnt=7, ovf[2]=1. Then:
  - ovf_clear[2] -> ovf[2]=0;
  - rise coinciding with ovf_clear -> ovf[2] remains 1.
- Simultaneous: source 7 ACTIVE with cnt=0; rise and complete_id=8 in the same cycle -> sources[7] stays 1 and cnt=0; the next complete drops it.
- Ignored ids:
  - complete_id=0 and 40 -> no state change on any source;
  - level-mode source receiving a complete -> sources unaffected;
  - toggling edge_mode[3] while ACTIVE with cnt=2 -> IDLE, cnt=0 next cycle.
